// File: rtl/uart_cmd_parser.sv
// Framed command parser behind a UART receiver: synchronizes rx_valid, assembles
// HEADER/cmd/arg/checksum packets, and drives registered motor-control outputs.
module uart_cmd_parser #(
   parameter int unsigned TIMEOUT = 1000,
   parameter logic [7:0]  HEADER  = 8'hA5
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic [2:0] speed,
   output logic       dir,
   output logic       stop,
   output logic       cmd_stb,
   output logic       tx_req,
   output logic [7:0] tx_data,
   output logic [7:0] err_cnt
);

   typedef enum logic [1:0] {IDLE, GOT_HDR, GOT_CMD, GOT_ARG} state_t;

   localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic        sync1_q, sync2_q, prev_q;
   logic        accept;
   logic [7:0]  cmd_q, cmd_d, arg_q, arg_d;
   logic [15:0] idle_q, idle_d;
   logic [2:0]  speed_q, speed_d;
   logic        dir_q, dir_d, stop_q, stop_d;
   logic        stb_q, stb_d, txreq_q, txreq_d;
   logic [7:0]  txdata_q, txdata_d, err_q, err_d;
   logic        err_inc;

   assign accept = sync2_q & ~prev_q;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         prev_q   <= 1'b0;
         state_q  <= IDLE;
         cmd_q    <= '0;
         arg_q    <= '0;
         idle_q   <= '0;
         speed_q  <= '0;
         dir_q    <= 1'b0;
         stop_q   <= 1'b1;
         stb_q    <= 1'b0;
         txreq_q  <= 1'b0;
         txdata_q <= '0;
         err_q    <= '0;
      end else begin
         sync1_q  <= rx_valid;
         sync2_q  <= sync1_q;
         prev_q   <= sync2_q;
         state_q  <= state_d;
         cmd_q    <= cmd_d;
         arg_q    <= arg_d;
         idle_q   <= idle_d;
         speed_q  <= speed_d;
         dir_q    <= dir_d;
         stop_q   <= stop_d;
         stb_q    <= stb_d;
         txreq_q  <= txreq_d;
         txdata_q <= txdata_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cmd_d    = cmd_q;
      arg_d    = arg_q;
      idle_d   = idle_q;
      speed_d  = speed_q;
      dir_d    = dir_q;
      stop_d   = stop_q;
      stb_d    = 1'b0;
      txreq_d  = 1'b0;
      txdata_d = txdata_q;
      err_inc  = 1'b0;

      // An accepted byte always takes priority over an expiring idle counter.
      if (accept) begin
         idle_d = '0;
         unique case (state_q)
            IDLE:    if (rx_data == HEADER) state_d = GOT_HDR;
            GOT_HDR: begin cmd_d = rx_data; state_d = GOT_CMD; end
            GOT_CMD: begin arg_d = rx_data; state_d = GOT_ARG; end
            GOT_ARG: begin
               state_d = IDLE;
               if (rx_data == (HEADER ^ cmd_q ^ arg_q)) begin
                  unique case (cmd_q)
                     8'h01: begin
                        speed_d = arg_q[2:0];
                        dir_d   = arg_q[7];
                        stop_d  = 1'b0;
                        stb_d   = 1'b1;
                     end
                     8'h02: begin
                        stop_d = 1'b1;
                        stb_d  = 1'b1;
                     end
                     8'h03: begin
                        txdata_d = {stop_q, dir_q, 3'b000, speed_q};
                        txreq_d  = 1'b1;
                        stb_d    = 1'b1;
                     end
                     default: err_inc = 1'b1;
                  endcase
               end else begin
                  err_inc = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end else if (state_q == IDLE) begin
         idle_d = '0;
      end else if (idle_q == TO_LAST) begin
         state_d = IDLE;
         idle_d  = '0;
         err_inc = 1'b1;
      end else begin
         idle_d = idle_q + 16'd1;
      end

      err_d = (err_inc && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;
   end

   assign speed   = speed_q;
   assign dir     = dir_q;
   assign stop    = stop_q;
   assign cmd_stb = stb_q;
   assign tx_req  = txreq_q;
   assign tx_data = txdata_q;
   assign err_cnt = err_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: directed scenarios plus randomized packets
// compared against a packet-level reference model built on a byte queue.
module tb_uart_cmd_parser;

   localparam logic [7:0] HDR = 8'hA5;

   logic       CLK = 1'b0;
   logic       RST_N = 1'b0;
   logic [7:0] rx_data = '0;
   logic       rx_valid = 1'b0;
   logic [2:0] speed;
   logic       dir, stop, cmd_stb, tx_req;
   logic [7:0] tx_data, err_cnt;

   int unsigned tests = 0;
   int unsigned fails = 0;

   // Reference model state
   logic [2:0] m_speed;
   logic       m_dir, m_stop;
   logic [7:0] m_tx, m_err;
   logic [7:0] pkt[$];
   int unsigned exp_stb = 0, exp_txr = 0;

   // Pulse observers
   int unsigned stb_cnt = 0, txr_cnt = 0, wide_cnt = 0;
   logic prev_stb = 1'b0, prev_txr = 1'b0;

   uart_cmd_parser #(.TIMEOUT(50), .HEADER(HDR)) dut (
      .CLK(CLK), .RST_N(RST_N), .rx_data(rx_data), .rx_valid(rx_valid),
      .speed(speed), .dir(dir), .stop(stop), .cmd_stb(cmd_stb),
      .tx_req(tx_req), .tx_data(tx_data), .err_cnt(err_cnt)
   );

   always #5 CLK = ~CLK;

   always @(negedge CLK) begin
      if (cmd_stb) stb_cnt++;
      if (tx_req) txr_cnt++;
      if ((cmd_stb && prev_stb) || (tx_req && prev_txr)) wide_cnt++;
      prev_stb = cmd_stb;
      prev_txr = tx_req;
   end

   function automatic logic [20:0] dut_vec();
      return {speed, dir, stop, tx_data, err_cnt};
   endfunction

   function automatic logic [20:0] exp_vec();
      return {m_speed, m_dir, m_stop, m_tx, m_err};
   endfunction

   function automatic void model_reset();
      m_speed = '0; m_dir = 1'b0; m_stop = 1'b1; m_tx = '0; m_err = '0;
      pkt.delete();
   endfunction

   function automatic void model_err();
      if (m_err != 8'hFF) m_err = m_err + 8'd1;
   endfunction

   function automatic void model_timeout();
      if (pkt.size() != 0) begin
         model_err();
         pkt.delete();
      end
   endfunction

   function automatic void model_byte(input logic [7:0] b);
      logic [7:0] c, a;
      if (pkt.size() == 0 && b != HDR) return;
      pkt.push_back(b);
      if (pkt.size() < 4) return;
      c = pkt[1];
      a = pkt[2];
      if (pkt[3] != (HDR ^ c ^ a)) model_err();
      else if (c == 8'h01) begin
         m_speed = a[2:0]; m_dir = a[7]; m_stop = 1'b0; exp_stb++;
      end else if (c == 8'h02) begin
         m_stop = 1'b1; exp_stb++;
      end else if (c == 8'h03) begin
         m_tx = {m_stop, m_dir, 3'b000, m_speed}; exp_stb++; exp_txr++;
      end else model_err();
      pkt.delete();
   endfunction

   task automatic send_byte(input logic [7:0] b, input int unsigned hold);
      @(negedge CLK);
      rx_data  = b;
      rx_valid = 1'b1;
      repeat (hold) @(negedge CLK);
      rx_valid = 1'b0;
      repeat (3) @(negedge CLK);
      model_byte(b);
   endtask

   task automatic send_pkt(input logic [7:0] b0, b1, b2, b3);
      send_byte(b0, 3); send_byte(b1, 3); send_byte(b2, 3); send_byte(b3, 3);
      repeat (2) @(negedge CLK);
   endtask

   task automatic test_reset();
      model_reset();
      RST_N = 1'b0;
      repeat (3) @(negedge CLK);
      tests++;
      if (dut_vec() !== exp_vec()) begin
         fails++; $display("FAIL reset_in: got %h want %h", dut_vec(), exp_vec());
      end
      RST_N = 1'b1;
      repeat (3) @(negedge CLK);
      tests++;
      if (dut_vec() !== exp_vec() || stb_cnt !== 0 || txr_cnt !== 0) begin
         fails++; $display("FAIL reset_out: got %h stb=%0d txr=%0d want %h 0 0",
                           dut_vec(), stb_cnt, txr_cnt, exp_vec());
      end
   endtask

   task automatic test_set();
      send_pkt(8'hA5, 8'h01, 8'h83, 8'h27);
      tests++;
      if (dut_vec() !== exp_vec() || {speed, dir, stop, err_cnt} !== {3'd3, 1'b1, 1'b0, 8'd0}) begin
         fails++; $display("FAIL set: got %h want %h", dut_vec(), exp_vec());
      end
      tests++;
      if (stb_cnt !== exp_stb || stb_cnt !== 1) begin
         fails++; $display("FAIL set_stb: got %0d want %0d", stb_cnt, exp_stb);
      end
   endtask

   task automatic test_stop_query();
      send_pkt(8'hA5, 8'h02, 8'h00, 8'hA7);
      tests++;
      if (dut_vec() !== exp_vec() || stop !== 1'b1 || speed !== 3'd3) begin
         fails++; $display("FAIL stop: got %h want %h", dut_vec(), exp_vec());
      end
      send_pkt(8'hA5, 8'h03, 8'h00, 8'hA6);
      tests++;
      if (dut_vec() !== exp_vec() || tx_data !== 8'hC3) begin
         fails++; $display("FAIL query: got %h want %h", dut_vec(), exp_vec());
      end
      tests++;
      if (txr_cnt !== exp_txr || stb_cnt !== exp_stb) begin
         fails++; $display("FAIL query_pulses: got txr=%0d stb=%0d want %0d %0d",
                           txr_cnt, stb_cnt, exp_txr, exp_stb);
      end
   endtask

   task automatic test_bad();
      int unsigned s0 = stb_cnt;
      send_pkt(8'hA5, 8'h01, 8'h05, 8'h00);
      tests++;
      if (dut_vec() !== exp_vec() || err_cnt !== 8'd1 || stb_cnt !== s0) begin
         fails++; $display("FAIL bad_chk: got %h stb=%0d want %h stb=%0d",
                           dut_vec(), stb_cnt, exp_vec(), s0);
      end
      send_pkt(8'hA5, 8'h07, 8'h00, 8'hA2);
      tests++;
      if (dut_vec() !== exp_vec() || err_cnt !== 8'd2 || stb_cnt !== s0) begin
         fails++; $display("FAIL bad_cmd: got %h want %h", dut_vec(), exp_vec());
      end
   endtask

   task automatic test_timeout();
      send_byte(8'hA5, 3);
      send_byte(8'h01, 3);
      repeat (60) @(negedge CLK);
      model_timeout();
      tests++;
      if (dut_vec() !== exp_vec()) begin
         fails++; $display("FAIL timeout: got %h want %h", dut_vec(), exp_vec());
      end
      send_byte(8'h83, 3);
      send_byte(8'h27, 3);
      repeat (60) @(negedge CLK);
      tests++;
      if (dut_vec() !== exp_vec() || stb_cnt !== exp_stb) begin
         fails++; $display("FAIL timeout_tail: got %h stb=%0d want %h stb=%0d",
                           dut_vec(), stb_cnt, exp_vec(), exp_stb);
      end
   endtask

   task automatic test_noise();
      send_byte(8'h00, 3); send_byte(8'hFF, 3); send_byte(8'h3C, 3);
      send_pkt(8'hA5, 8'h01, 8'h02, 8'hA6);
      tests++;
      if (dut_vec() !== exp_vec() || speed !== 3'd2 || dir !== 1'b0 || stb_cnt !== exp_stb) begin
         fails++; $display("FAIL noise: got %h stb=%0d want %h stb=%0d",
                           dut_vec(), stb_cnt, exp_vec(), exp_stb);
      end
   endtask

   task automatic test_level_hold();
      send_byte(8'hA5, 20);
      send_byte(8'h01, 3); send_byte(8'h85, 3); send_byte(8'h21, 3);
      repeat (2) @(negedge CLK);
      tests++;
      if (dut_vec() !== exp_vec() || stb_cnt !== exp_stb) begin
         fails++; $display("FAIL level_hold: got %h stb=%0d want %h stb=%0d",
                           dut_vec(), stb_cnt, exp_vec(), exp_stb);
      end
   endtask

   task automatic test_reset_mid();
      send_byte(8'hA5, 3);
      send_byte(8'h01, 3);
      @(negedge CLK);
      RST_N = 1'b0;
      model_reset();
      repeat (3) @(negedge CLK);
      tests++;
      if (dut_vec() !== exp_vec()) begin
         fails++; $display("FAIL reset_mid: got %h want %h", dut_vec(), exp_vec());
      end
      RST_N = 1'b1;
      send_byte(8'h83, 3);
      send_byte(8'h27, 3);
      repeat (3) @(negedge CLK);
      tests++;
      if (dut_vec() !== exp_vec() || stb_cnt !== exp_stb) begin
         fails++; $display("FAIL reset_tail: got %h stb=%0d want %h stb=%0d",
                           dut_vec(), stb_cnt, exp_vec(), exp_stb);
      end
   endtask

   task automatic test_random();
      logic [7:0] c, a, k, n;
      for (int i = 0; i < 60; i++) begin
         case ($urandom_range(0, 4))
            0: c = 8'h01;
            1: c = 8'h01;
            2: c = 8'h02;
            3: c = 8'h03;
            default: c = 8'($urandom);
         endcase
         a = 8'($urandom);
         k = HDR ^ c ^ a;
         if ($urandom_range(0, 3) == 0) k = k ^ 8'($urandom_range(1, 255));
         if ($urandom_range(0, 4) == 0) begin
            n = 8'($urandom);
            if (n == HDR) n = 8'h5A;
            send_byte(n, 3);
         end
         send_pkt(HDR, c, a, k);
         tests++;
         if (dut_vec() !== exp_vec() || stb_cnt !== exp_stb || txr_cnt !== exp_txr) begin
            fails++; $display("FAIL random[%0d]: got %h stb=%0d txr=%0d want %h stb=%0d txr=%0d",
                              i, dut_vec(), stb_cnt, txr_cnt, exp_vec(), exp_stb, exp_txr);
         end
      end
   endtask

   task automatic test_back_to_back();
      send_byte(8'hA5, 3); send_byte(8'h01, 3); send_byte(8'h04, 3); send_byte(8'hA0, 3);
      send_byte(8'hA5, 3); send_byte(8'h03, 3); send_byte(8'hA5, 3); send_byte(8'h03, 3);
      repeat (2) @(negedge CLK);
      tests++;
      if (dut_vec() !== exp_vec() || stb_cnt !== exp_stb || txr_cnt !== exp_txr) begin
         fails++; $display("FAIL back_to_back: got %h stb=%0d txr=%0d want %h stb=%0d txr=%0d",
                           dut_vec(), stb_cnt, txr_cnt, exp_vec(), exp_stb, exp_txr);
      end
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 300; i++) send_pkt(8'hA5, 8'h01, 8'h05, 8'h00);
      tests++;
      if (dut_vec() !== exp_vec() || err_cnt !== 8'hFF) begin
         fails++; $display("FAIL saturation: got %h want %h", dut_vec(), exp_vec());
      end
      tests++;
      if (wide_cnt !== 0) begin
         fails++; $display("FAIL pulse_width: got %0d wide pulses want 0", wide_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_set();
      test_stop_query();
      test_bad();
      test_timeout();
      test_noise();
      test_level_hold();
      test_reset_mid();
      test_random();
      test_back_to_back();
      test_saturation();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
